// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH+1 steps per product.
// Operands are extended to WIDTH+1 bits so one datapath serves both signed and unsigned modes.
module booth_multiplier_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 is_signed,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH+1:0]   a_q, a_d;
    logic [WIDTH:0]     q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic               done_q, done_d;

    logic               last_step;
    logic [WIDTH+1:0]   sum;

    assign last_step = (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_d    = m_q;
        a_d    = a_q;
        q_d    = q_q;
        qm1_d  = qm1_q;
        cnt_d  = cnt_q;
        z_d    = z_q;
        done_d = 1'b0;
        sum    = a_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d   = {is_signed & x[WIDTH-1], x};
                    q_d   = {is_signed & y[WIDTH-1], y};
                    qm1_d = 1'b0;
                    a_d   = '0;
                    cnt_d = CW'(WIDTH + 1);
                end
            end
            RUN: begin
                case ({q_q[0], qm1_q})
                    2'b01:   sum = a_q + {m_q[WIDTH], m_q};
                    2'b10:   sum = a_q - {m_q[WIDTH], m_q};
                    default: sum = a_q;
                endcase
                // Arithmetic right shift of the whole {A, Q, q-1} chain.
                a_d   = {sum[WIDTH+1], sum[WIDTH+1:1]};
                q_d   = {sum[0], q_q[WIDTH:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q - CW'(1);
                if (last_step) begin
                    z_d    = {a_d[WIDTH-2:0], q_d};
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        z    = z_q;
    end

endmodule
